// File: rtl/key_ctrl_pkg.sv
// key_ctrl_pkg: shared widths, limits and the controller state type for key_load_ctrl.
//   KEY_W    : width of one key byte
//   MAX_KEYS : largest key count a load sequence may request
//   KEYS_W   : width of the committed key bus (MAX_KEYS keys packed)
package key_ctrl_pkg;

  localparam int unsigned KEY_W    = 8;
  localparam int unsigned MAX_KEYS = 4;
  localparam int unsigned KEYS_W   = 32;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned IDX_W    = 2;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCommit,
    StActive
  } state_e;

  // A load request is honoured only for 1..MAX_KEYS keys.
  function automatic logic count_legal(input logic [CNT_W-1:0] count);
    return (count != '0) && (count <= CNT_W'(MAX_KEYS));
  endfunction

endpackage

// File: rtl/key_sel.sv
// key_sel: picks one key byte out of the packed committed key bus.
//   i_keys : committed keys, key i at bits [8i+7:8i]
//   i_idx  : index of the key to select
//   o_key  : selected key byte
module key_sel
  import key_ctrl_pkg::*;
(
  input  logic [KEYS_W-1:0] i_keys,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [KEY_W-1:0]  o_key
);

  always_comb begin
    o_key = i_keys[KEY_W-1:0];
    case (i_idx)
      2'd0:    o_key = i_keys[7:0];
      2'd1:    o_key = i_keys[15:8];
      2'd2:    o_key = i_keys[23:16];
      default: o_key = i_keys[31:24];
    endcase
  end

endmodule

// File: rtl/key_load_ctrl.sv
// key_load_ctrl: sequences loading of up to four key bytes into an external key register
// and then serves committed keys round-robin on request.
//   dclk, reset          : clock, asynchronous active-high reset
//   start, key_count     : begin a load of key_count (1..4) bytes
//   in_data/valid/ready  : byte input handshake, accepted when in_valid && in_ready
//   kr_clr/din/we/kset   : key register clear, data, write strobe, commit pulse
//   num_keys, keys       : committed contents read back from the key register
//   key_req              : ask for the next key; answer on key_out/key_vld next cycle
//   busy, err            : load in progress; single-cycle error pulse
module key_load_ctrl
  import key_ctrl_pkg::*;
(
  input  logic              dclk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  key_count,
  input  logic [KEY_W-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              kr_clr,
  output logic [KEY_W-1:0]  kr_din,
  output logic              kr_we,
  output logic              kr_kset,
  input  logic [CNT_W-1:0]  num_keys,
  input  logic [KEYS_W-1:0] keys,
  input  logic              key_req,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_vld,
  output logic              busy,
  output logic              err
);

  state_e             r_state;
  logic [CNT_W-1:0]   r_target;
  logic [CNT_W-1:0]   r_loaded;
  logic [IDX_W-1:0]   r_idx;
  logic               r_kr_clr;
  logic [KEY_W-1:0]   r_kr_din;
  logic               r_kr_we;
  logic               r_kr_kset;
  logic [KEY_W-1:0]   r_key_out;
  logic               r_key_vld;
  logic               r_err;

  state_e             w_state_nxt;
  logic [CNT_W-1:0]   w_target_nxt;
  logic [CNT_W-1:0]   w_loaded_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_kr_clr_nxt;
  logic [KEY_W-1:0]   w_kr_din_nxt;
  logic               w_kr_we_nxt;
  logic               w_kr_kset_nxt;
  logic [KEY_W-1:0]   w_key_out_nxt;
  logic               w_key_vld_nxt;
  logic               w_err_nxt;

  logic [KEY_W-1:0]   w_sel_key;
  logic               w_idx_last;

  key_sel u_key_sel (
    .i_keys (keys),
    .i_idx  (r_idx),
    .o_key  (w_sel_key)
  );

  assign w_idx_last = ({1'b0, r_idx} == (num_keys - 3'd1));

  always_comb begin
    w_state_nxt   = r_state;
    w_target_nxt  = r_target;
    w_loaded_nxt  = r_loaded;
    w_idx_nxt     = r_idx;
    w_kr_clr_nxt  = 1'b0;
    w_kr_din_nxt  = r_kr_din;
    w_kr_we_nxt   = 1'b0;
    w_kr_kset_nxt = 1'b0;
    w_key_out_nxt = r_key_out;
    w_key_vld_nxt = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      StIdle, StActive: begin
        // start has priority over key_req; a same-cycle request is dropped.
        if (start) begin
          if (count_legal(key_count)) begin
            w_target_nxt = key_count;
            w_loaded_nxt = '0;
            w_kr_clr_nxt = 1'b1;
            w_state_nxt  = StLoad;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if ((r_state == StActive) && key_req) begin
          if (num_keys == '0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_key_out_nxt = w_sel_key;
            w_key_vld_nxt = 1'b1;
            w_idx_nxt     = w_idx_last ? '0 : r_idx + 2'd1;
          end
        end
      end
      StLoad: begin
        if (in_valid) begin
          w_kr_din_nxt = in_data;
          w_kr_we_nxt  = 1'b1;
          if (r_loaded != CNT_W'(MAX_KEYS)) begin
            w_loaded_nxt = r_loaded + 3'd1;
          end
          if (r_loaded == (r_target - 3'd1)) begin
            w_state_nxt = StCommit;
          end
        end
      end
      StCommit: begin
        // Commit is registered, so it lands one cycle after the last write strobe.
        w_kr_kset_nxt = 1'b1;
        w_idx_nxt     = '0;
        w_state_nxt   = StActive;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_target  <= '0;
      r_loaded  <= '0;
      r_idx     <= '0;
      r_kr_clr  <= 1'b0;
      r_kr_din  <= '0;
      r_kr_we   <= 1'b0;
      r_kr_kset <= 1'b0;
      r_key_out <= '0;
      r_key_vld <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_target  <= w_target_nxt;
      r_loaded  <= w_loaded_nxt;
      r_idx     <= w_idx_nxt;
      r_kr_clr  <= w_kr_clr_nxt;
      r_kr_din  <= w_kr_din_nxt;
      r_kr_we   <= w_kr_we_nxt;
      r_kr_kset <= w_kr_kset_nxt;
      r_key_out <= w_key_out_nxt;
      r_key_vld <= w_key_vld_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign in_ready = (r_state == StLoad);
  assign busy     = (r_state == StLoad) || (r_state == StCommit);
  assign kr_clr   = r_kr_clr;
  assign kr_din   = r_kr_din;
  assign kr_we    = r_kr_we;
  assign kr_kset  = r_kr_kset;
  assign key_out  = r_key_out;
  assign key_vld  = r_key_vld;
  assign err      = r_err;

endmodule

// File: tb/tb_key_load_ctrl.sv
// tb_key_load_ctrl: directed scenarios plus randomized traffic for key_load_ctrl, each cycle
// compared against a behavioural model of the load/commit/serve rules.
module tb_key_load_ctrl;

  logic        dclk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  key_count = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic [2:0]  num_keys = '0;
  logic [31:0] keys = '0;
  logic        key_req = 1'b0;

  logic        in_ready, kr_clr, kr_we, kr_kset, key_vld, busy, err;
  logic [7:0]  kr_din, key_out;

  int n_checks = 0;
  int n_errors = 0;

  key_load_ctrl dut (
    .dclk      (dclk),
    .reset     (reset),
    .start     (start),
    .key_count (key_count),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .kr_clr    (kr_clr),
    .kr_din    (kr_din),
    .kr_we     (kr_we),
    .kr_kset   (kr_kset),
    .num_keys  (num_keys),
    .keys      (keys),
    .key_req   (key_req),
    .key_out   (key_out),
    .key_vld   (key_vld),
    .busy      (busy),
    .err       (err)
  );

  always #5 dclk = ~dclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: phase of the sequence, byte counts, and the visible outputs.
  localparam int M_IDLE = 0, M_LOAD = 1, M_COMMIT = 2, M_ACTIVE = 3;
  int         m_mode;
  int         m_target, m_loaded, m_idx;
  logic [7:0] m_din, m_kout;
  bit         m_clr, m_we, m_kset, m_vld, m_err;

  // Pulse counters and captured served keys for the directed scenarios.
  int         c_clr, c_we, c_kset, c_cycle, we3_cycle, kset_cycle;
  logic [7:0] served[$];

  task automatic model_reset();
    m_mode = M_IDLE; m_target = 0; m_loaded = 0; m_idx = 0;
    m_din = '0; m_kout = '0;
    m_clr = 0; m_we = 0; m_kset = 0; m_vld = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit nclr = 0, nwe = 0, nkset = 0, nvld = 0, nerr = 0;
    case (m_mode)
      M_IDLE, M_ACTIVE: begin
        if (start) begin
          if (key_count >= 1 && key_count <= 4) begin
            m_target = int'(key_count);
            m_loaded = 0;
            nclr = 1;
            m_mode = M_LOAD;
          end else begin
            nerr = 1;
          end
        end else if (m_mode == M_ACTIVE && key_req) begin
          if (num_keys == 0) begin
            nerr = 1;
          end else begin
            m_kout = keys[8*m_idx +: 8];
            nvld = 1;
            m_idx = (m_idx == int'(num_keys) - 1) ? 0 : (m_idx + 1) % 4;
          end
        end
      end
      M_LOAD: begin
        if (in_valid) begin
          m_din = in_data;
          nwe = 1;
          m_loaded++;
          if (m_loaded == m_target) m_mode = M_COMMIT;
        end
      end
      default: begin
        nkset = 1;
        m_idx = 0;
        m_mode = M_ACTIVE;
      end
    endcase
    m_clr = nclr; m_we = nwe; m_kset = nkset; m_vld = nvld; m_err = nerr;
  endtask

  task automatic compare_all();
    check("in_ready", in_ready, m_mode == M_LOAD);
    check("busy", busy, m_mode == M_LOAD || m_mode == M_COMMIT);
    check("kr_clr", kr_clr, m_clr);
    check("kr_din", kr_din, m_din);
    check("kr_we", kr_we, m_we);
    check("kr_kset", kr_kset, m_kset);
    check("key_out", key_out, m_kout);
    check("key_vld", key_vld, m_vld);
    check("err", err, m_err);
  endtask

  // Called at a falling edge: drive inputs, step model, wait one cycle, compare, tally pulses.
  task automatic drive(input logic s, input logic [2:0] kc, input logic [7:0] d,
                       input logic v, input logic kr);
    start = s; key_count = kc; in_data = d; in_valid = v; key_req = kr;
    model_step();
    @(negedge dclk);
    compare_all();
    c_cycle++;
    if (kr_clr) c_clr++;
    if (kr_we) begin
      c_we++;
      if (c_we == 3) we3_cycle = c_cycle;
    end
    if (kr_kset) begin
      c_kset++;
      kset_cycle = c_cycle;
    end
    if (key_vld) served.push_back(key_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    c_clr = 0; c_we = 0; c_kset = 0; c_cycle = 0; we3_cycle = -1; kset_cycle = -1;
    served.delete();
  endtask

  // Assert reset mid-cycle and check outputs clear before any clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_kr_clr", kr_clr, 0);
    check("rst_kr_din", kr_din, 0);
    check("rst_kr_we", kr_we, 0);
    check("rst_kr_kset", kr_kset, 0);
    check("rst_key_out", key_out, 0);
    check("rst_key_vld", key_vld, 0);
    check("rst_err", err, 0);
    model_reset();
    start = 0; key_count = 0; in_data = 0; in_valid = 0; key_req = 0;
    @(negedge dclk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] exp051 [6];
    exp051 = '{8'h02, 8'h06, 8'h0E, 8'h1E, 8'h02, 8'h06};
    model_reset();
    repeat (2) @(negedge dclk);
    compare_all();
    reset = 1'b0;

    // Two-key load.
    clear_counts();
    drive(1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 8'h02, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 8'h06, 1'b1, 1'b0);
    idle(3);
    check("t050_clr_cnt", c_clr, 1);
    check("t050_we_cnt", c_we, 2);
    check("t050_kset_cnt", c_kset, 1);
    check("t050_din_last", kr_din, 8'h06);
    check("t050_busy_active", busy, 0);

    // Four-key load then six round-robin requests.
    num_keys = 3'd4;
    keys = 32'h1E0E0602;
    drive(1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 8'h02, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 8'h06, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 8'h0E, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 8'h1E, 1'b1, 1'b0);
    idle(2);
    clear_counts();
    for (int i = 0; i < 6; i++) drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    check("t051_served_cnt", served.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < served.size()) check($sformatf("t051_key%0d", i), served[i], exp051[i]);
    end

    // start and key_req together in ACTIVE.
    clear_counts();
    drive(1'b1, 3'd1, 8'h00, 1'b0, 1'b1);
    check("t055_no_vld", key_vld, 0);
    check("t055_clr", kr_clr, 1);
    check("t055_in_load", in_ready, 1);
    drive(1'b0, 3'd0, 8'h55, 1'b1, 1'b0);
    idle(3);

    // Three keys with gapped in_valid.
    clear_counts();
    drive(1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b0, 3'd0, 8'(8'h30 + i), 1'(i % 2 == 0), 1'b0);
    idle(2);
    check("t053_we_cnt", c_we, 3);
    check("t053_kset_cnt", c_kset, 1);
    check("t053_kset_after_we3", kset_cycle, we3_cycle + 1);

    // Reset after two of four bytes.
    clear_counts();
    drive(1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 8'hA1, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 8'hA2, 1'b1, 1'b0);
    do_reset();
    idle(4);
    check("t054_no_kset", c_kset, 0);
    check("t054_idle_ready", in_ready, 0);
    check("t054_idle_busy", busy, 0);

    // Illegal counts.
    drive(1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
    check("t052_err_cnt0", err, 1);
    drive(1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
    check("t052_err_cnt5", err, 1);
    idle(1);
    check("t052_err_gone", err, 0);
    check("t052_in_ready", in_ready, 0);
    check("t052_busy", busy, 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        num_keys = 3'($urandom_range(0, 4));
        keys = $urandom;
      end
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        drive(1'($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)), 8'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_load_ctrl.md
KEY_LOAD_CTRL -- requirements
Module: key_load_ctrl

Interface
REQ-001 SHALL have ports: dclk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  begin key-load sequence; key_count  in  3  number of keys to load (legal 1..4).
REQ-004 SHALL have ports: in_data  in  8  key byte; in_valid  in  1  byte offered; in_ready  out  1  byte accepted when in_valid&&in_ready.
REQ-005 SHALL have ports: kr_clr  out  1  clear pulse to key register; kr_din  out  8  key byte to key register; kr_we  out  1  write strobe; kr_kset  out  1  latch/commit pulse.
REQ-006 SHALL have ports: num_keys  in  3  committed key count from key register; keys  in  32  committed keys, key i at bits [8i+7:8i].
REQ-007 SHALL have ports: key_req  in  1  request next round key; key_out  out  8  selected key; key_vld  out  1  key_out valid; busy  out  1  load in progress; err  out  1  error pulse.

Function
REQ-010 SHALL implement states IDLE, LOAD, COMMIT, ACTIVE.
REQ-011 IDLE/ACTIVE + start with key_count in 1..4: latch target=key_count, loaded=0, pulse kr_clr 1 cycle, go LOAD next cycle.
REQ-012 start with key_count 0 or >4: pulse err 1 cycle, state unchanged.
REQ-013 start while in LOAD or COMMIT SHALL be ignored, no err.
REQ-014 LOAD: in_ready=1 (combinational from state); outside LOAD in_ready=0.
REQ-015 Each accepted byte: kr_din<=in_data and kr_we=1 in the following cycle (1-cycle latency), loaded increments by 1 (3-bit, no wrap past 4).
REQ-016 Byte accepted with loaded==target-1: go COMMIT next cycle.
REQ-017 COMMIT: kr_kset=1 exactly 1 cycle, kr_we=0, then ACTIVE with idx=0.
REQ-018 busy=1 in LOAD and COMMIT, else 0.
REQ-019 ACTIVE + key_req: key_out<=keys[8*idx+:8], key_vld=1 next cycle for 1 cycle; idx<=idx+1, wrapping to 0 when idx==num_keys-1.
REQ-020 ACTIVE + key_req with num_keys==0: key_vld=0, err pulse 1 cycle, idx unchanged.
REQ-021 key_req outside ACTIVE SHALL be ignored (no key_vld, no err).
REQ-022 start and key_req same cycle in ACTIVE: start wins, key_req dropped, idx reset to 0 on re-entry to ACTIVE.
REQ-023 kr_we, kr_kset, kr_clr, key_vld, err SHALL be single-cycle pulses, never held.
REQ-024 kr_din SHALL hold its last value between writes.

Reset
REQ-030 reset asserted SHALL immediately force: state IDLE, idx 0, loaded 0, target 0, in_ready 0, kr_clr 0, kr_din 0, kr_we 0, kr_kset 0, key_out 0, key_vld 0, busy 0, err 0.
REQ-031 reset mid-LOAD SHALL abandon the sequence with no kr_kset pulse; key register content is not guaranteed valid until next full load.
REQ-032 First start honoured on the first dclk edge after reset deasserts.

Structure
REQ-040 Package key_ctrl_pkg SHALL hold KEY_W=8, MAX_KEYS=4, KEYS_W=32 and the state enum.
REQ-041 Key-select mux (keys, idx -> byte) SHALL be sub-module key_sel; key register itself is instantiated at top level, not inside this block.

Verification
REQ-050 reset, start key_count=2, bytes 0x02,0x06 -> kr_clr 1 pulse, kr_we twice with kr_din 0x02 then 0x06, kr_kset 1 pulse, busy low in ACTIVE.
REQ-051 load 4 keys 0x02,0x06,0x0E,0x1E, num_keys=4, keys=0x1E0E0602, 6 key_req -> key_out 0x02,0x06,0x0E,0x1E,0x02,0x06 each with key_vld.
REQ-052 start key_count=0 and key_count=5 -> err pulse, state IDLE, in_ready 0.
REQ-053 in_valid toggled 1/0 during LOAD of 3 keys -> exactly 3 kr_we pulses, kr_kset only after third accepted byte.
REQ-054 reset asserted after 2 of 4 bytes -> all outputs zero same cycle, no kr_kset, IDLE after release.
REQ-055 ACTIVE, start(count=1) and key_req same cycle -> no key_vld, kr_clr pulse, LOAD entered.
